// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Presents ALU operands, opcode, shift amount and gated control to the EX stage.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_inputA,
    output logic [DATA_W-1:0] ex_inputB,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [3:0]        ex_alu_ctrl,
    output logic [4:0]        ex_shamt,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [3:0]        alu_ctrl;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
    } ex_reg_t;

    ex_reg_t ex_d, ex_q;

    logic fwd_exmem_rs, fwd_memwb_rs, fwd_exmem_rt, fwd_memwb_rt;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    // A load in EX whose destination is read by the instruction in ID.
    assign hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && id_valid
                          && ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));

    always_comb begin
        // NOTE: ex_d starts as a copy of ex_q so every path assigns it and no latch is inferred.
        ex_d = ex_q;
        if (flush || (!stall_in && hazard_stall)) begin
            ex_d = '0;
        end else if (!stall_in) begin
            ex_d.valid      = id_valid;
            ex_d.rs_data    = id_rs_data;
            ex_d.rt_data    = id_rt_data;
            ex_d.imm        = id_imm;
            ex_d.shamt      = id_shamt;
            ex_d.alu_ctrl   = id_alu_ctrl;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.dest       = id_reg_dst ? id_rd : id_rt;
            ex_d.alu_src    = id_alu_src;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            ex_d.branch     = id_branch;
        end
    end

    // NOTE: non-blocking assignment so the whole register updates atomically at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; register 0 is never forwarded.
    assign fwd_exmem_rs = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rs);
    assign fwd_memwb_rs = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rs);
    assign fwd_exmem_rt = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rt);
    assign fwd_memwb_rt = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rt);

    assign fwd_rs = fwd_exmem_rs ? exmem_result : (fwd_memwb_rs ? memwb_result : ex_q.rs_data);
    assign fwd_rt = fwd_exmem_rt ? exmem_result : (fwd_memwb_rt ? memwb_result : ex_q.rt_data);

    assign ex_valid      = ex_q.valid;
    assign ex_inputA     = fwd_rs;
    assign ex_inputB     = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_shamt      = ex_q.shamt;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;
    assign ex_branch     = ex_q.valid & ex_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX outputs are queued when ID
// stimulus is driven and compared one cycle later.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
    logic        id_mem_to_reg, id_branch;
    logic        stall_in, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        hazard_stall, ex_valid;
    logic [31:0] ex_inputA, ex_inputB, ex_store_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_shamt, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_ctrl(id_alu_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .stall_in(stall_in), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_inputA(ex_inputA), .ex_inputB(ex_inputB), .ex_store_data(ex_store_data),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_shamt(ex_shamt), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    typedef struct {
        logic        valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt;
        logic [3:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic        alu_src, reg_dst, rw, mr, mw, m2r, br;
    } id_t;

    typedef struct {
        logic        valid;
        logic [31:0] a, b, sd;
        logic [3:0]  ctrl;
        logic [4:0]  shamt, dest;
        logic        rw, mr, mw, m2r, br;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: ID fields as they should appear in EX when no forwarding is active.
    function automatic exp_t model(input id_t i);
        exp_t e;
        e.valid = i.valid;
        e.a     = i.rs_data;
        e.sd    = i.rt_data;
        e.b     = i.alu_src ? i.imm : i.rt_data;
        e.ctrl  = i.ctrl;
        e.shamt = i.shamt;
        e.dest  = i.reg_dst ? i.rd : i.rt;
        e.rw    = i.valid & i.rw;
        e.mr    = i.valid & i.mr;
        e.mw    = i.valid & i.mw;
        e.m2r   = i.valid & i.m2r;
        e.br    = i.valid & i.br;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 1'b0; e.a = '0; e.b = '0; e.sd = '0; e.ctrl = '0; e.shamt = '0; e.dest = '0;
        e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.m2r = 1'b0; e.br = 1'b0;
        return e;
    endfunction

    function automatic id_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
        id_t i;
        i.valid = valid; i.rs = rs; i.rt = rt; i.rd = rd; i.rs_data = rsd; i.rt_data = rtd;
        i.imm = '0; i.shamt = '0; i.ctrl = 4'd0; i.alu_src = 1'b0; i.reg_dst = 1'b1;
        i.rw = 1'b1; i.mr = 1'b0; i.mw = 1'b0; i.m2r = 1'b0; i.br = 1'b0;
        return i;
    endfunction

    task automatic apply(input id_t i);
        id_valid = i.valid; id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm;
        id_shamt = i.shamt; id_alu_ctrl = i.ctrl; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_alu_src = i.alu_src; id_reg_dst = i.reg_dst; id_reg_write = i.rw;
        id_mem_read = i.mr; id_mem_write = i.mw; id_mem_to_reg = i.m2r; id_branch = i.br;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    // Advance one edge, then compare the DUT against the oldest queued expectation.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        check({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_valid"}, 32'(ex_valid), 32'(e.valid));
            check({tag, "_inA"},   ex_inputA,     e.a);
            check({tag, "_inB"},   ex_inputB,     e.b);
            check({tag, "_sd"},    ex_store_data, e.sd);
            check({tag, "_ctrl"},  32'(ex_alu_ctrl), 32'(e.ctrl));
            check({tag, "_shamt"}, 32'(ex_shamt), 32'(e.shamt));
            check({tag, "_dest"},  32'(ex_dest),  32'(e.dest));
            check({tag, "_rw"},    32'(ex_reg_write),  32'(e.rw));
            check({tag, "_mr"},    32'(ex_mem_read),   32'(e.mr));
            check({tag, "_mw"},    32'(ex_mem_write),  32'(e.mw));
            check({tag, "_m2r"},   32'(ex_mem_to_reg), 32'(e.m2r));
            check({tag, "_br"},    32'(ex_branch),     32'(e.br));
        end
    endtask

    initial begin
        id_t  x, h, lw;
        exp_t e;

        rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
        clear_fwd();
        apply(mk(1'b1, 5'd9, 5'd10, 5'd11, 32'hDEAD, 32'hBEEF));

        // Reset with a valid instruction pending
        sb_q.push_back(bubble());
        step("reset");
        check("reset_hazard", 32'(hazard_stall), 32'd0);
        rst_n = 1'b1;

        // Basic add
        x = mk(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        apply(x);
        sb_q.push_back(model(x));
        step("add");

        // EX/MEM beats MEM/WB; MEM/WB used once EX/MEM stops writing
        x = mk(1'b1, 5'd1, 5'd2, 5'd3, 32'h99, 32'h7);
        x.ctrl = 4'd1; x.shamt = 5'd4; x.br = 1'b1;
        apply(x);
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h10;
        memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_result = 32'h20;
        e = model(x); e.a = 32'h10;
        sb_q.push_back(e);
        step("fwd_exmem");
        exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb_inA", ex_inputA, 32'h20);
        memwb_rd = 5'd2;
        #1;
        check("fwd_memwb_sd", ex_store_data, 32'h20);
        check("fwd_memwb_inB", ex_inputB, 32'h20);
        clear_fwd();

        // Load-use hazard
        lw = mk(1'b1, 5'd5, 5'd4, 5'd0, 32'h100, 32'h0);
        lw.reg_dst = 1'b0; lw.mr = 1'b1; lw.m2r = 1'b1; lw.alu_src = 1'b1; lw.imm = 32'd8;
        apply(lw);
        sb_q.push_back(model(lw));
        step("lw");
        apply(mk(1'b0, 5'd4, 5'd6, 5'd7, 32'h1, 32'h2));
        #1;
        check("hazard_invalid_id", 32'(hazard_stall), 32'd0);
        h = mk(1'b1, 5'd4, 5'd6, 5'd7, 32'h44, 32'h66);
        apply(h);
        #1;
        check("hazard_rs", 32'(hazard_stall), 32'd1);
        sb_q.push_back(bubble());
        step("hazard_bubble");
        check("hazard_clear", 32'(hazard_stall), 32'd0);
        sb_q.push_back(model(h));
        step("hazard_retry");

        // Stall holds for three cycles, then flush overrides stall
        x = mk(1'b1, 5'd12, 5'd13, 5'd14, 32'h1234, 32'h5678);
        x.ctrl = 4'd6; x.mw = 1'b1; x.shamt = 5'd31;
        apply(x);
        sb_q.push_back(model(x));
        step("pre_stall");
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            h = mk(1'b1, 5'(k + 16), 5'(k + 20), 5'(k + 24), $urandom, $urandom);
            h.ctrl = 4'(k + 2);
            apply(h);
            sb_q.push_back(model(x));
            step("stall");
        end
        flush = 1'b1;
        sb_q.push_back(bubble());
        step("flush_stall");
        flush = 1'b0; stall_in = 1'b0;

        // Register 0 is never forwarded
        x = mk(1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0);
        apply(x);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hEE;
        sb_q.push_back(model(x));
        step("r0_nofwd");
        clear_fwd();

        // Negative immediate on inputB, then reset while stalled and valid
        x = mk(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22);
        x.alu_src = 1'b1; x.imm = 32'hFFFF_FFFC; x.ctrl = 4'd7;
        apply(x);
        sb_q.push_back(model(x));
        step("imm_neg");
        apply(mk(1'b1, 5'd6, 5'd7, 5'd8, 32'h33, 32'h44));
        stall_in = 1'b1; rst_n = 1'b0;
        sb_q.push_back(bubble());
        step("reset_mid");
        check("reset_mid_hazard", 32'(hazard_stall), 32'd0);
        rst_n = 1'b1; stall_in = 1'b0;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
